// File: rtl/helix_reactor_mc.sv
//----------------------------------------------------------------------------
//  Module      : helix_reactor_mc
//  Description : Multi-channel context folder. Each context beat updates the
//                accumulator for its channel according to a per-beat
//                precision mode. The last beat of a packet pushes the tagged,
//                fully updated thought into an output FIFO and clears that
//                channel's accumulator.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

`ifndef HELIX_CONTEXT_W
`define HELIX_CONTEXT_W 8
`endif
`ifndef HELIX_THOUGHT_W
`define HELIX_THOUGHT_W 16
`endif

module helix_reactor_mc #(
    parameter int CONTEXT_W  = `HELIX_CONTEXT_W,
    parameter int THOUGHT_W  = `HELIX_THOUGHT_W,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter bit SATURATE   = 1'b0,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctx_valid,
    output logic                 ctx_ready,
    input  logic [CONTEXT_W-1:0] ctx_data,
    input  logic [CH_W-1:0]      ctx_ch,
    input  logic                 ctx_last,
    input  logic [1:0]           precision_mode,
    output logic                 thought_valid,
    input  logic                 thought_ready,
    output logic [THOUGHT_W-1:0] thought_data,
    output logic [CH_W-1:0]      thought_ch,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 err_bad_ch
);

    localparam int               PTR_W  = $clog2(FIFO_DEPTH);
    localparam int               ENT_W  = CH_W + THOUGHT_W;
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(FIFO_DEPTH);

    // Folding state and output queue
    logic [THOUGHT_W-1:0] r_acc [NUM_CH];
    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_ch_ok;
    logic                 w_push;
    logic                 w_pop;
    logic [THOUGHT_W-1:0] w_ext;
    logic [THOUGHT_W-1:0] w_cur;
    logic [THOUGHT_W-1:0] w_new;
    logic [THOUGHT_W:0]   w_sum;

    // Backpressure depends only on registered occupancy, never on thought_ready
    assign ctx_ready = (r_level != C_FULL);
    assign w_accept  = ctx_valid & ctx_ready;

    // Out-of-range channel codes only exist when NUM_CH is not a power of two
    generate
        if ((1 << CH_W) == NUM_CH) begin : g_ch_pow2
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_range
            assign w_ch_ok = ({1'b0, ctx_ch} < (CH_W + 1)'(NUM_CH));
        end
    endgenerate

    assign w_push = w_accept & w_ch_ok & ctx_last;
    assign w_pop  = (r_level != '0) & thought_ready;

    assign w_ext  = {{(THOUGHT_W - CONTEXT_W){1'b0}}, ctx_data};
    assign w_sum  = {1'b0, w_cur} + {1'b0, w_ext};

    // Select the addressed channel's accumulator; invalid channels read as zero
    always_comb begin
        w_cur = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctx_ch == CH_W'(c)) begin
                w_cur = r_acc[c];
            end
        end
    end

    // Fold the incoming beat into the current accumulator value
    always_comb begin
        w_new = w_ext;
        case (precision_mode)
            2'b00:   w_new = w_ext;
            2'b01:   w_new = {ctx_data, w_cur[THOUGHT_W-1:CONTEXT_W]};
            2'b10:   w_new = w_cur ^ w_ext;
            default: begin
                if (SATURATE && w_sum[THOUGHT_W]) begin
                    w_new = '1;
                end else begin
                    w_new = w_sum[THOUGHT_W-1:0];
                end
            end
        endcase
    end

    // Per-channel accumulators: update on accepted beats, clear on packet end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_accept && w_ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ctx_ch == CH_W'(c)) begin
                    r_acc[c] <= ctx_last ? '0 : w_new;
                end
            end
        end
    end

    // FIFO storage: entries cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {ctx_ch, w_new};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // One-cycle flag for a consumed beat that addressed a nonexistent channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_ch_ok;
        end
    end

    assign thought_valid              = (r_level != '0);
    assign {thought_ch, thought_data} = r_mem[r_rd_ptr];
    assign fifo_level                 = r_level;
    assign err_bad_ch                 = r_err;

endmodule

`default_nettype wire

// File: tb/tb_helix_reactor_mc.sv
//----------------------------------------------------------------------------
//  Module      : tb_helix_reactor_mc
//  Description : Self-checking bench for helix_reactor_mc. Two instances run
//                side by side on shared stimulus: a 4-channel wrapping build
//                and a 3-channel saturating build, each against its own
//                behavioural model.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_helix_reactor_mc;

    localparam int NDUT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctx_valid;
    logic [7:0] ctx_data;
    logic [1:0] ctx_ch;
    logic       ctx_last;
    logic [1:0] precision_mode;
    logic       thought_ready;

    logic        rdy [NDUT];
    logic        tv  [NDUT];
    logic [15:0] td  [NDUT];
    logic [1:0]  tc  [NDUT];
    logic [2:0]  lvl [NDUT];
    logic        err [NDUT];

    always #5 clk = ~clk;

    helix_reactor_mc #(
        .CONTEXT_W(8), .THOUGHT_W(16), .NUM_CH(4), .FIFO_DEPTH(4), .SATURATE(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .ctx_valid(ctx_valid), .ctx_ready(rdy[0]), .ctx_data(ctx_data),
        .ctx_ch(ctx_ch), .ctx_last(ctx_last), .precision_mode(precision_mode),
        .thought_valid(tv[0]), .thought_ready(thought_ready),
        .thought_data(td[0]), .thought_ch(tc[0]),
        .fifo_level(lvl[0]), .err_bad_ch(err[0])
    );

    helix_reactor_mc #(
        .CONTEXT_W(8), .THOUGHT_W(16), .NUM_CH(3), .FIFO_DEPTH(4), .SATURATE(1'b1)
    ) dut_sat3 (
        .clk(clk), .rst(rst),
        .ctx_valid(ctx_valid), .ctx_ready(rdy[1]), .ctx_data(ctx_data),
        .ctx_ch(ctx_ch), .ctx_last(ctx_last), .precision_mode(precision_mode),
        .thought_valid(tv[1]), .thought_ready(thought_ready),
        .thought_data(td[1]), .thought_ch(tc[1]),
        .fifo_level(lvl[1]), .err_bad_ch(err[1])
    );

    // Reference model state, one set per instance
    int          nch [NDUT] = '{4, 3};
    bit          sat [NDUT] = '{1'b0, 1'b1};
    logic [15:0] m_acc [NDUT][4];
    logic [17:0] m_q   [NDUT][4];   // {channel, thought}, index 0 is the head
    int          m_cnt [NDUT];
    bit          m_err [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fold rules computed with plain integer arithmetic
    function automatic logic [15:0] fold(input logic [1:0] md, input logic [15:0] acc,
                                         input logic [7:0] d, input bit s);
        int a;
        int x;
        int sum;
        a = int'(acc);
        x = int'(d);
        case (md)
            2'd0:    return 16'(x);
            2'd1:    return 16'((a / 256) + x * 256);
            2'd2:    return 16'(a ^ x);
            default: begin
                sum = a + x;
                if (sum > 65535) return s ? 16'hFFFF : 16'(sum - 65536);
                return 16'(sum);
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            for (int c = 0; c < 4; c++) m_acc[k][c] = '0;
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] ch,
                        input logic last, input logic [1:0] md, input logic tr);
        bit          exp_rdy;
        bit          acc;
        logic [15:0] nv;
        ctx_valid      = v;
        ctx_data       = d;
        ctx_ch         = ch;
        ctx_last       = last;
        precision_mode = md;
        thought_ready  = tr;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            exp_rdy = (m_cnt[k] != 4);
            chk($sformatf("ctx_ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy));
            chk($sformatf("thought_valid[%0d]", k), 32'(tv[k]), 32'(m_cnt[k] != 0));
            chk($sformatf("fifo_level[%0d]", k), 32'(lvl[k]), 32'(m_cnt[k]));
            chk($sformatf("err_bad_ch[%0d]", k), 32'(err[k]), 32'(m_err[k]));
            if (m_cnt[k] != 0) begin
                chk($sformatf("thought_data[%0d]", k), 32'(td[k]), 32'(m_q[k][0][15:0]));
                chk($sformatf("thought_ch[%0d]", k), 32'(tc[k]), 32'(m_q[k][0][17:16]));
            end
            acc = v && exp_rdy;
            if (m_cnt[k] != 0 && tr) begin
                for (int e = 0; e < 3; e++) m_q[k][e] = m_q[k][e+1];
                m_cnt[k]--;
            end
            m_err[k] = acc && (int'(ch) >= nch[k]);
            if (acc && int'(ch) < nch[k]) begin
                nv = fold(md, m_acc[k][ch], d, sat[k]);
                if (last) begin
                    m_q[k][m_cnt[k]] = {ch, nv};
                    m_cnt[k]++;
                    m_acc[k][ch] = '0;
                end else begin
                    m_acc[k][ch] = nv;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic tr);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'd0, 1'b0, 2'd0, tr);
    endtask

    int trp;

    initial begin
        rst            = 1'b1;
        ctx_valid      = 1'b0;
        ctx_data       = '0;
        ctx_ch         = '0;
        ctx_last       = 1'b0;
        precision_mode = '0;
        thought_ready  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 32'(tv[k]), 32'd0);
            chk($sformatf("rst_level[%0d]", k), 32'(lvl[k]), 32'd0);
            chk($sformatf("rst_data[%0d]", k), 32'(td[k]), 32'd0);
            chk($sformatf("rst_ch[%0d]", k), 32'(tc[k]), 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'd0);
        end
        rst = 1'b0;
        idle(1, 1'b1);

        // Add mode accumulation, emitted one cycle after the last beat
        step(1'b1, 8'h10, 2'd0, 1'b0, 2'd3, 1'b0);
        step(1'b1, 8'h20, 2'd0, 1'b0, 2'd3, 1'b0);
        step(1'b1, 8'h30, 2'd0, 1'b1, 2'd3, 1'b0);
        chk("t1_valid", 32'(tv[0]), 32'd1);
        chk("t1_data", 32'(td[0]), 32'h0060);
        idle(1, 1'b1);
        step(1'b1, 8'h01, 2'd0, 1'b1, 2'd3, 1'b0);
        chk("t1_cleared", 32'(td[0]), 32'h0001);
        idle(2, 1'b1);

        // Interleaved shift-in and xor packets
        step(1'b1, 8'hAB, 2'd1, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h0F, 2'd2, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'hFF, 2'd2, 1'b1, 2'd2, 1'b0);
        step(1'b1, 8'hCD, 2'd1, 1'b1, 2'd1, 1'b0);
        chk("t2_head", 32'(td[0]), 32'h00F0);
        chk("t2_head_ch", 32'(tc[0]), 32'd2);
        idle(1, 1'b1);
        chk("t2_second", 32'(td[0]), 32'hCDAB);
        idle(2, 1'b1);

        // Fill the FIFO, hold the fifth beat, then drain
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 2'd0, 1'b1, 2'd0, 1'b0);
        chk("t3_level_full", 32'(lvl[0]), 32'd4);
        chk("t3_not_ready", 32'(rdy[0]), 32'd0);
        step(1'b1, 8'h05, 2'd0, 1'b1, 2'd0, 1'b1);
        step(1'b1, 8'h05, 2'd0, 1'b1, 2'd0, 1'b1);
        idle(6, 1'b1);

        // Overflow: wrap on the 4-channel build, clamp on the saturating build
        step(1'b1, 8'hFF, 2'd2, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'hFF, 2'd2, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h05, 2'd2, 1'b1, 2'd3, 1'b0);
        chk("t4_wrap", 32'(td[0]), 32'h0004);
        chk("t4_sat", 32'(td[1]), 32'hFFFF);
        // Channel 3 is valid on one build and out of range on the other
        step(1'b1, 8'hFF, 2'd3, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'hFF, 2'd3, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h05, 2'd3, 1'b1, 2'd3, 1'b0);
        chk("t5_err_pulse", 32'(err[1]), 32'd1);
        chk("t5_level_kept", 32'(lvl[1]), 32'd1);
        chk("t5_level_other", 32'(lvl[0]), 32'd2);
        idle(4, 1'b1);

        // Asynchronous reset with queued thoughts and a partial packet
        step(1'b1, 8'h11, 2'd1, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h22, 2'd1, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'h33, 2'd1, 1'b0, 2'd3, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("t6_valid[%0d]", k), 32'(tv[k]), 32'd0);
            chk($sformatf("t6_level[%0d]", k), 32'(lvl[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h01, 2'd1, 1'b1, 2'd3, 1'b0);
        chk("t6_fresh0", 32'(td[0]), 32'h0001);
        chk("t6_fresh1", 32'(td[1]), 32'h0001);
        idle(2, 1'b1);

        // Randomized traffic with varying consumer backpressure
        trp = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) trp = $urandom_range(1, 9);
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                 $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 9) < trp);
        end
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
